// File: rtl/dual_issue_ctrl_pkg.sv
// dual_issue_ctrl_pkg: shared state encoding and counter width default for the issue scheduler.
package dual_issue_ctrl_pkg;
    localparam int CNT_W_DEF = 32;
    typedef enum logic {S_FIRST = 1'b0, S_SECOND = 1'b1} state_e;
endpackage

// File: rtl/dual_issue_ctrl_issue_hazard_chk.sv
// issue_hazard_chk: decides whether a decoded instruction pair may issue together.
module issue_hazard_chk (
    input  logic       in_valid1,
    input  logic       is_alu0,
    input  logic       is_alu1,
    input  logic       is_serial0,
    input  logic       is_serial1,
    input  logic [4:0] rd0,
    input  logic       we0,
    input  logic [4:0] rd1,
    input  logic [4:0] rj1,
    input  logic [4:0] rk1,
    output logic       dual_ok
);
    logic wr0;
    logic raw;
    logic waw;
    always_comb begin
        wr0     = we0 && rd0 != 5'd0;
        raw     = wr0 && (rd0 == rj1 || rd0 == rk1);
        waw     = wr0 && rd0 == rd1;
        dual_ok = in_valid1 && is_alu0 && is_alu1 && !is_serial0 && !is_serial1 && !raw && !waw;
    end
endmodule

// File: rtl/dual_issue_ctrl.sv
// dual_issue_ctrl: issues the held instruction pair to the EX1 lanes as a dual, split or stalled
// issue, serializes privileged ops behind a drained pipe and counts dual/single issues.
module dual_issue_ctrl
    import dual_issue_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             in_valid1,
    input  logic             is_alu0,
    input  logic             is_alu1,
    input  logic             is_serial0,
    input  logic             is_serial1,
    input  logic [4:0]       rd0,
    input  logic [4:0]       rd1,
    input  logic             we0,
    input  logic [4:0]       rj1,
    input  logic [4:0]       rk1,
    input  logic             pipe_empty,
    input  logic             ex_allowin,
    output logic             in_allowin,
    output logic             lane0_valid,
    output logic             lane0_sel,
    output logic             lane1_valid,
    output logic [CNT_W-1:0] cnt_dual,
    output logic [CNT_W-1:0] cnt_single
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_dual_q, cnt_dual_d;
    logic [CNT_W-1:0] cnt_single_q, cnt_single_d;
    logic             dual_ok;
    logic             inc_dual;
    logic             inc_single;

    issue_hazard_chk u_hazard (
        .in_valid1 (in_valid1),
        .is_alu0   (is_alu0),
        .is_alu1   (is_alu1),
        .is_serial0(is_serial0),
        .is_serial1(is_serial1),
        .rd0       (rd0),
        .we0       (we0),
        .rd1       (rd1),
        .rj1       (rj1),
        .rk1       (rk1),
        .dual_ok   (dual_ok)
    );

    always_comb begin
        state_d     = state_q;
        lane0_valid = 1'b0;
        lane0_sel   = 1'b0;
        lane1_valid = 1'b0;
        in_allowin  = 1'b0;
        inc_dual    = 1'b0;
        inc_single  = 1'b0;
        if (!aresetn) begin
            state_d = S_FIRST;
        end else if (flush) begin
            state_d    = S_FIRST;
            in_allowin = 1'b1;
        end else if (state_q == S_FIRST) begin
            if (!in_valid) begin
                in_allowin = 1'b1;
            end else if (!(is_serial0 && !pipe_empty)) begin
                lane0_valid = 1'b1;
                lane1_valid = dual_ok;
                // a split pair stays in the stage register until slot1 goes
                if (ex_allowin) begin
                    inc_dual   = dual_ok;
                    inc_single = !dual_ok;
                    in_allowin = dual_ok || !in_valid1;
                    state_d    = (!dual_ok && in_valid1) ? S_SECOND : S_FIRST;
                end
            end
        end else if (!(is_serial1 && !pipe_empty)) begin
            lane0_valid = 1'b1;
            lane0_sel   = 1'b1;
            if (ex_allowin) begin
                in_allowin = 1'b1;
                inc_single = 1'b1;
                state_d    = S_FIRST;
            end
        end
        cnt_dual_d   = cnt_dual_q + CNT_W'(inc_dual);
        cnt_single_d = cnt_single_q + CNT_W'(inc_single);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q      <= S_FIRST;
            cnt_dual_q   <= '0;
            cnt_single_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_dual_q   <= cnt_dual_d;
            cnt_single_q <= cnt_single_d;
        end
    end

    assign cnt_dual   = cnt_dual_q;
    assign cnt_single = cnt_single_q;
endmodule

// File: tb/tb_dual_issue_ctrl.sv
// tb_dual_issue_ctrl: directed and randomized checks of dual_issue_ctrl against a slot-level model.
module tb_dual_issue_ctrl;
    localparam int W = 8;

    logic         aclk = 1'b0;
    logic         aresetn, flush, in_valid, in_valid1, is_alu0, is_alu1, is_serial0, is_serial1;
    logic         we0, pipe_empty, ex_allowin;
    logic [4:0]   rd0, rd1, rj1, rk1;
    logic         in_allowin, lane0_valid, lane0_sel, lane1_valid;
    logic [W-1:0] cnt_dual, cnt_single;

    int          checks = 0;
    int          errors = 0;
    int          issued = 0;
    int unsigned md = 0, ms = 0;
    logic        e_l0v, e_sel, e_l1v, e_allow, e_id, e_is;
    int          e_issued;

    dual_issue_ctrl #(.CNT_W(W)) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_valid1  (in_valid1),
        .is_alu0    (is_alu0),
        .is_alu1    (is_alu1),
        .is_serial0 (is_serial0),
        .is_serial1 (is_serial1),
        .rd0        (rd0),
        .rd1        (rd1),
        .we0        (we0),
        .rj1        (rj1),
        .rk1        (rk1),
        .pipe_empty (pipe_empty),
        .ex_allowin (ex_allowin),
        .in_allowin (in_allowin),
        .lane0_valid(lane0_valid),
        .lane0_sel  (lane0_sel),
        .lane1_valid(lane1_valid),
        .cnt_dual   (cnt_dual),
        .cnt_single (cnt_single)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // issued counts how many slots of the held pair already went to EX1
    task automatic model();
        logic hz, dual;
        e_l0v = 0; e_sel = 0; e_l1v = 0; e_allow = 0; e_id = 0; e_is = 0;
        e_issued = issued;
        hz   = we0 && rd0 != 0 && (rd0 == rj1 || rd0 == rk1 || rd0 == rd1);
        dual = in_valid1 && is_alu0 && is_alu1 && !is_serial0 && !is_serial1 && !hz;
        if (!aresetn) begin
            e_issued = 0;
        end else if (flush) begin
            e_allow = 1; e_issued = 0;
        end else if (issued == 0) begin
            if (!in_valid) e_allow = 1;
            else if (!(is_serial0 && !pipe_empty)) begin
                e_l0v = 1; e_l1v = dual;
                if (ex_allowin) begin
                    if (dual) e_id = 1; else e_is = 1;
                    if (!dual && in_valid1) e_issued = 1; else e_allow = 1;
                end
            end
        end else if (!(is_serial1 && !pipe_empty)) begin
            e_l0v = 1; e_sel = 1;
            if (ex_allowin) begin e_allow = 1; e_is = 1; e_issued = 0; end
        end
    endtask

    task automatic tick();
        model();
        @(negedge aclk);
        check("lane0_valid", 64'(lane0_valid), 64'(e_l0v));
        check("lane0_sel", 64'(lane0_sel), 64'(e_sel));
        check("lane1_valid", 64'(lane1_valid), 64'(e_l1v));
        check("in_allowin", 64'(in_allowin), 64'(e_allow));
        check("cnt_dual", 64'(cnt_dual), 64'(md));
        check("cnt_single", 64'(cnt_single), 64'(ms));
        @(posedge aclk);
        if (!aresetn) begin
            issued = 0; md = 0; ms = 0;
        end else begin
            issued = e_issued;
            md = (md + 32'(e_id)) % (1 << W);
            ms = (ms + 32'(e_is)) % (1 << W);
        end
        #1;
    endtask

    task automatic pair(input logic v1, a0, a1, s0, s1, w, input logic [4:0] d0, d1, j, k);
        in_valid = 1; in_valid1 = v1; is_alu0 = a0; is_alu1 = a1; is_serial0 = s0; is_serial1 = s1;
        we0 = w; rd0 = d0; rd1 = d1; rj1 = j; rk1 = k;
    endtask

    initial begin
        aresetn = 0; flush = 0; pipe_empty = 1; ex_allowin = 1;
        in_valid = 0; in_valid1 = 0; is_alu0 = 0; is_alu1 = 0; is_serial0 = 0; is_serial1 = 0;
        we0 = 0; rd0 = 0; rd1 = 0; rj1 = 0; rk1 = 0;
        #1;
        tick();
        tick();
        aresetn = 1;
        pair(1, 1, 1, 0, 0, 1, 5, 8, 6, 7);
        tick();
        check("dual_first", 64'(cnt_dual), 64'd1);
        pair(1, 1, 1, 0, 0, 1, 5, 8, 5, 7);
        tick();
        tick();
        check("raw_split", 64'(cnt_single), 64'd2);
        pair(1, 1, 1, 0, 0, 1, 0, 8, 0, 0);
        tick();
        check("r0_dual", 64'(cnt_dual), 64'd2);
        pair(1, 1, 1, 1, 0, 1, 3, 4, 1, 2);
        pipe_empty = 0;
        repeat (3) tick();
        pipe_empty = 1;
        tick();
        tick();
        check("serial_split", 64'(cnt_single), 64'd4);
        pair(1, 1, 1, 0, 0, 1, 5, 8, 5, 7);
        tick();
        ex_allowin = 0;
        tick();
        tick();
        ex_allowin = 1;
        tick();
        check("hold_second", 64'(cnt_single), 64'd6);
        tick();
        flush = 1;
        tick();
        flush = 0;
        in_valid = 0;
        tick();
        check("flush_cnt", 64'(cnt_single), 64'd7);
        pair(1, 1, 1, 0, 0, 1, 5, 8, 6, 7);
        for (int i = 0; i < 300 && md != (1 << W) - 1; i++) tick();
        check("pre_wrap", 64'(cnt_dual), 64'((1 << W) - 1));
        tick();
        check("wrap", 64'(cnt_dual), 64'd0);
        pair(1, 1, 1, 0, 0, 1, 5, 8, 5, 7);
        tick();
        aresetn = 0;
        tick();
        aresetn = 1;
        check("rst_dual", 64'(cnt_dual), 64'd0);
        check("rst_single", 64'(cnt_single), 64'd0);
        for (int i = 0; i < 3000; i++) begin
            if (!(in_valid && !e_allow)) begin
                in_valid   = $urandom_range(0, 9) != 0;
                in_valid1  = $urandom_range(0, 3) != 0;
                is_alu0    = $urandom_range(0, 3) != 0;
                is_alu1    = $urandom_range(0, 3) != 0;
                is_serial0 = $urandom_range(0, 7) == 0;
                is_serial1 = $urandom_range(0, 7) == 0;
                we0        = $urandom_range(0, 3) != 0;
                rd0        = 5'($urandom_range(0, 3));
                rd1        = 5'($urandom_range(0, 3));
                rj1        = 5'($urandom_range(0, 3));
                rk1        = 5'($urandom_range(0, 3));
            end
            ex_allowin = $urandom_range(0, 3) != 0;
            pipe_empty = $urandom_range(0, 1) != 0;
            flush      = $urandom_range(0, 19) == 0;
            aresetn    = $urandom_range(0, 49) != 0;
            tick();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
